// File: rtl/usb_pkt_tx_gen.sv
// USB token/handshake/SOF packet transmitter: queues packet requests and serialises
// each one as a byte stream (PID, then two field/CRC5 bytes for tokens and SOF).
module usb_pkt_tx_gen #(
    parameter int QUEUE_DEPTH = 2,
    parameter bit SOF_ENABLE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   tx_pid,
    input  logic [6:0]                   tx_addr,
    input  logic [3:0]                   tx_endp,
    input  logic [10:0]                  tx_frame,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         tx_err,
    output logic [$clog2(QUEUE_DEPTH):0] tx_level,
    output logic                         tx_to_sop,
    output logic                         tx_to_eop,
    output logic                         tx_to_valid,
    input  logic                         tx_to_ready,
    output logic [7:0]                   tx_to_data,
    output logic                         tx_con_pid_en,
    output logic [3:0]                   tx_con_pid,
    output logic                         tx_busy
);

    localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_B1, ST_B2} state_t;

    // Queue entry: {is_handshake, pid, 11-bit field}
    typedef struct packed {
        logic        hs;
        logic [3:0]  pid;
        logic [10:0] f;
    } entry_t;

    state_t              state;
    entry_t              q_mem [QUEUE_DEPTH];
    entry_t              push_entry;
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    q_cnt;
    logic                cls_hs;
    logic                cls_sof;
    logic                pid_ok;
    logic                accept;
    logic                push_ok;
    logic                pop;
    logic                xfer;
    logic                cur_hs;
    logic [10:0]         cur_f;
    logic [4:0]          crc_o;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Bit-serial CRC5 (x^5+x^2+1), field LSB first, inverted and bit-reversed on output
    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = d[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return {~c[0], ~c[1], ~c[2], ~c[3], ~c[4]};
    endfunction

    assign crc_o = crc5(cur_f);

    // PID classification at the queue input
    assign cls_hs  = (tx_pid[1:0] == 2'b10);
    assign cls_sof = SOF_ENABLE && (tx_pid == 4'b0101);
    assign pid_ok  = cls_hs || ((tx_pid[1:0] == 2'b01) && ((tx_pid != 4'b0101) || SOF_ENABLE));

    assign push_entry.hs  = cls_hs;
    assign push_entry.pid = tx_pid;
    assign push_entry.f   = cls_sof ? tx_frame : {tx_endp, tx_addr};

    assign tx_ready = (q_cnt != LVL_W'(QUEUE_DEPTH));
    assign tx_level = q_cnt;
    assign accept   = tx_valid && tx_ready;
    assign push_ok  = accept && pid_ok;
    assign xfer     = tx_to_valid && tx_to_ready;
    assign head     = q_mem[rd_ptr];

    // Pop on idle or on the last byte of a packet, so packets chain without a bubble
    assign pop     = (q_cnt != '0) && ((state == ST_IDLE) || (xfer && tx_to_eop));
    assign tx_busy = (q_cnt != '0) || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (push_ok) q_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            tx_err <= 1'b0;
        end else begin
            tx_err <= accept && !pid_ok;
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop})
                2'b10:   q_cnt <= q_cnt + LVL_W'(1);
                2'b01:   q_cnt <= q_cnt - LVL_W'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_hs        <= 1'b0;
            cur_f         <= '0;
            tx_to_valid   <= 1'b0;
            tx_to_sop     <= 1'b0;
            tx_to_eop     <= 1'b0;
            tx_to_data    <= 8'h00;
            tx_con_pid_en <= 1'b0;
            tx_con_pid    <= 4'h0;
        end else if (pop) begin
            state         <= ST_PID;
            cur_hs        <= head.hs;
            cur_f         <= head.f;
            tx_to_valid   <= 1'b1;
            tx_to_sop     <= 1'b1;
            tx_to_eop     <= head.hs;
            tx_to_data    <= {~head.pid, head.pid};
            tx_con_pid_en <= 1'b1;
            tx_con_pid    <= head.pid;
        end else if (xfer && tx_to_eop) begin
            state         <= ST_IDLE;
            tx_to_valid   <= 1'b0;
            tx_to_sop     <= 1'b0;
            tx_to_eop     <= 1'b0;
            tx_to_data    <= 8'h00;
            tx_con_pid_en <= 1'b0;
        end else if (xfer) begin
            case (state)
                ST_PID: begin
                    state         <= ST_B1;
                    tx_to_sop     <= 1'b0;
                    tx_to_eop     <= 1'b0;
                    tx_to_data    <= cur_f[7:0];
                    tx_con_pid_en <= 1'b0;
                end
                ST_B1: begin
                    state      <= ST_B2;
                    tx_to_eop  <= 1'b1;
                    tx_to_data <= {crc_o, cur_f[10:8]};
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_pkt_tx_gen.sv
// Directed bench for usb_pkt_tx_gen: scoreboard of expected bytes checked by a byte monitor,
// plus directed checks of queue, error, backpressure and reset behaviour.
module tb_usb_pkt_tx_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  tx_pid = 4'h0;
    logic [6:0]  tx_addr = 7'h0;
    logic [3:0]  tx_endp = 4'h0;
    logic [10:0] tx_frame = 11'h0;
    logic        tx_valid = 1'b0;
    logic        v0 = 1'b0;
    logic        tx_to_ready = 1'b1;

    logic        tx_ready, tx_err, tx_to_sop, tx_to_eop, tx_to_valid, tx_con_pid_en, tx_busy;
    logic [1:0]  tx_level;
    logic [7:0]  tx_to_data;
    logic [3:0]  tx_con_pid;

    logic        z_ready, z_err, z_sop, z_eop, z_valid, z_pid_en, z_busy;
    logic [1:0]  z_level;
    logic [7:0]  z_data;
    logic [3:0]  z_pid;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [9:0]  sb [$];

    always #5 clk = ~clk;

    usb_pkt_tx_gen #(.QUEUE_DEPTH(2), .SOF_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_frame(tx_frame), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_err(tx_err),
        .tx_level(tx_level), .tx_to_sop(tx_to_sop), .tx_to_eop(tx_to_eop),
        .tx_to_valid(tx_to_valid), .tx_to_ready(tx_to_ready), .tx_to_data(tx_to_data),
        .tx_con_pid_en(tx_con_pid_en), .tx_con_pid(tx_con_pid), .tx_busy(tx_busy)
    );

    usb_pkt_tx_gen #(.QUEUE_DEPTH(2), .SOF_ENABLE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_frame(tx_frame), .tx_valid(v0), .tx_ready(z_ready), .tx_err(z_err),
        .tx_level(z_level), .tx_to_sop(z_sop), .tx_to_eop(z_eop),
        .tx_to_valid(z_valid), .tx_to_ready(tx_to_ready), .tx_to_data(z_data),
        .tx_con_pid_en(z_pid_en), .tx_con_pid(z_pid), .tx_busy(z_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC5: serial LFSR over the 11-bit field, LSB first
    function automatic logic [4:0] crc5_ref(input logic [10:0] d);
        logic [4:0] r;
        r = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            if (d[i] != r[4]) r = {r[3:0], 1'b0} ^ 5'b00101;
            else              r = {r[3:0], 1'b0};
        end
        return ~{r[0], r[1], r[2], r[3], r[4]};
    endfunction

    task automatic exp_byte(input logic sop, input logic eop, input logic [7:0] d);
        sb.push_back({sop, eop, d});
    endtask

    task automatic exp_pkt(input logic [3:0] pid, input logic [10:0] f);
        exp_byte(1'b1, pid[1:0] == 2'b10, {~pid, pid});
        if (pid[1:0] != 2'b10) begin
            exp_byte(1'b0, 1'b0, f[7:0]);
            exp_byte(1'b0, 1'b1, {crc5_ref(f), f[10:8]});
        end
    endtask

    task automatic push(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                        input logic [10:0] fr);
        int n;
        tx_pid = pid; tx_addr = a; tx_endp = e; tx_frame = fr; tx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {sb.size() == 0, tx_busy}, 2'b10);
        @(posedge clk); #1;
    endtask

    // Byte monitor: every transfer must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && tx_to_valid && tx_to_ready) begin
            chk("byte_expected", sb.size() != 0, 1);
            if (sb.size() != 0) chk("byte", {tx_to_sop, tx_to_eop, tx_to_data}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  a;
        logic [3:0]  e;
        logic [10:0] fr;
        logic [3:0]  pids [3];
        logic        acc;
        pids[0] = 4'h1; pids[1] = 4'h9; pids[2] = 4'hD;

        // Reset values
        @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_err", tx_err, 0);
        chk("rst_level", tx_level, 0);
        chk("rst_vse", {tx_to_valid, tx_to_sop, tx_to_eop}, 3'b000);
        chk("rst_data", tx_to_data, 8'h00);
        chk("rst_con", {tx_con_pid_en, tx_con_pid}, 5'h00);
        chk("rst_busy", tx_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Handshake ACK
        exp_byte(1'b1, 1'b1, 8'hD2);
        push(4'h2, 7'h0, 4'h0, 11'h0);
        @(negedge clk);
        chk("hs_busy_q", {tx_busy, tx_level}, 3'b101);
        @(negedge clk);
        chk("hs_valid", tx_to_valid, 1);
        chk("hs_con", {tx_con_pid_en, tx_con_pid}, 5'h12);
        @(negedge clk);
        chk("hs_con_clr", tx_con_pid_en, 0);
        chk("hs_busy_fall", tx_busy, 0);
        drain();

        // SETUP to address 0 endpoint 0
        exp_byte(1'b1, 1'b0, 8'h2D);
        exp_byte(1'b0, 1'b0, 8'h00);
        exp_byte(1'b0, 1'b1, 8'h10);
        push(4'hD, 7'h0, 4'h0, 11'h0);
        drain();

        // Random tokens against the CRC model
        for (int k = 0; k < 3; k++) begin
            a = 7'($urandom);
            e = 4'($urandom);
            exp_pkt(pids[k], {e, a});
            push(pids[k], a, e, 11'h0);
        end
        drain();

        // SOF frames
        exp_byte(1'b1, 1'b0, 8'hA5);
        exp_byte(1'b0, 1'b0, 8'h00);
        exp_byte(1'b0, 1'b1, 8'h10);
        push(4'h5, 7'h7F, 4'hF, 11'h000);
        fr = 11'($urandom_range(0, 2047));
        exp_pkt(4'h5, fr);
        push(4'h5, 7'h0, 4'h0, fr);
        drain();

        // SOF with SOF_ENABLE=0 is rejected
        tx_pid = 4'h5; tx_frame = 11'h0; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("sof_dis_err", z_err, 1);
        chk("sof_dis_level", z_level, 0);
        @(negedge clk);
        chk("sof_dis_err_pulse", z_err, 0);
        repeat (4) @(negedge clk);
        chk("sof_dis_idle", {z_valid, z_busy, z_level}, 4'h0);
        @(posedge clk); #1;

        // DATA0 rejected, following token sent normally
        tx_pid = 4'h3; tx_valid = 1'b1;
        @(posedge clk); #1;
        a = 7'($urandom); e = 4'($urandom);
        tx_pid = 4'h1; tx_addr = a; tx_endp = e;
        exp_pkt(4'h1, {e, a});
        @(negedge clk);
        chk("rej_err", tx_err, 1);
        chk("rej_level", tx_level, 0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rej_err_pulse", tx_err, 0);
        chk("rej_tok_level", tx_level, 1);
        drain();

        // Backpressure with a full queue, then back-to-back release
        tx_to_ready = 1'b0;
        exp_pkt(4'h9, {4'h3, 7'h15});
        push(4'h9, 7'h15, 4'h3, 11'h0);
        exp_byte(1'b1, 1'b1, 8'hD2);
        push(4'h2, 7'h0, 4'h0, 11'h0);
        exp_pkt(4'h1, {4'h8, 7'h2A});
        push(4'h1, 7'h2A, 4'h8, 11'h0);
        exp_byte(1'b1, 1'b1, 8'h5A);
        tx_pid = 4'hA; tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", tx_ready, 0);
            chk("bp_level", tx_level, 2);
            chk("bp_hold", {tx_to_valid, tx_to_sop, tx_to_data}, 10'h369);
        end
        @(posedge clk); #1;
        tx_to_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_bubble", tx_to_valid, 1);
            acc = tx_valid && tx_ready;
            @(posedge clk); #1;
            if (acc) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        drain();

        // Reset while in B1 with one entry queued
        tx_to_ready = 1'b0;
        exp_pkt(4'h9, {4'h2, 7'h33});
        push(4'h9, 7'h33, 4'h2, 11'h0);
        exp_byte(1'b1, 1'b1, 8'hD2);
        push(4'h2, 7'h0, 4'h0, 11'h0);
        @(negedge clk);
        chk("mid_pid", {tx_level, tx_to_data}, 10'h169);
        @(posedge clk); #1;
        tx_to_ready = 1'b1;
        @(posedge clk); #1;
        tx_to_ready = 1'b0;
        @(negedge clk);
        chk("mid_b1", {tx_level, tx_to_sop, tx_to_data}, 11'h233);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mr_vse", {tx_to_valid, tx_to_sop, tx_to_eop}, 3'b000);
        chk("mr_data", tx_to_data, 8'h00);
        chk("mr_level", tx_level, 0);
        chk("mr_ready_busy", {tx_ready, tx_busy}, 2'b10);
        chk("mr_con", {tx_con_pid_en, tx_con_pid}, 5'h00);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_to_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("mr_silent", tx_to_valid, 0);
        end
        chk("mr_level_after", {tx_level, tx_busy}, 3'b000);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
